// File: rtl/recog_pkg.sv
// Shared definitions for the sequence-recognizer event path.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package recog_pkg;

    localparam int TS_W_DEF  = 8;
    localparam int DEPTH_DEF = 4;
    localparam int CNT_W_DEF = 8;

    // Occupancy-derived control state of the event queue.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } fsm_state_t;

    // Ceiling log2, never below 1, for pointer and level widths.
    function automatic int clog2w(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/recog_evt_fifo.sv
// Synchronous FIFO holding event timestamps; level-based full/empty.
// Latency: 1 cycle push-to-visible; dout is a combinational read at rd_ptr.
// Backpressure: push when full is accepted only if a pop happens on the same edge; pop when empty is ignored.
//
// Ports: clk, reset (async active-high), push/din write side, pop/dout read side,
//        full/empty flags and level (occupancy, log2(DEPTH)+1 bits).
module recog_evt_fifo
    import recog_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DW-1:0]           din,
    output logic [DW-1:0]           dout,
    output logic                    full,
    output logic                    empty,
    output logic [clog2w(DEPTH):0]  level
);

    localparam int AW   = clog2w(DEPTH);
    localparam int LVLW = AW + 1;
    localparam logic [LVLW-1:0] LVL_FULL = LVLW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == LVL_FULL);
    assign empty   = (level == '0);
    assign pop_ok  = pop && !empty;
    // A full queue still takes a write when the head leaves on the same edge.
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVLW'(1);
                2'b01:   level <= level - LVLW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage is not reset; contents are only observed through level.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/recog_event_logger.sv
// Timestamps recognizer pulses and queues them for a valid/ready consumer.
// Latency: 1 cycle from the sampling edge of recognized to evt_valid; no empty bypass.
// Backpressure: evt_ready low holds entries; a pulse into a full queue without a pop is dropped and flagged.
//
// Ports: clk, reset (async active-high), recognized (event pulse),
//        evt_valid/evt_ready/evt_ts (head entry handshake), evt_count (saturating total),
//        dropped (sticky overflow), fifo_level (occupancy).
module recog_event_logger
    import recog_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    recognized,
    input  logic                    evt_ready,
    output logic                    evt_valid,
    output logic [TS_W-1:0]         evt_ts,
    output logic [CNT_W-1:0]        evt_count,
    output logic                    dropped,
    output logic [clog2w(DEPTH):0]  fifo_level
);

    localparam int LVLW = clog2w(DEPTH) + 1;
    localparam logic [LVLW-1:0] LVL_ONE    = LVLW'(1);
    localparam logic [LVLW-1:0] LVL_ALMOST = LVLW'(DEPTH - 1);

    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] fifo_dout;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop_ok;
    logic            push_ok;
    fsm_state_t      state;

    assign evt_valid = (state != ST_EMPTY);
    assign pop_ok    = evt_valid && evt_ready;
    assign push_ok   = recognized && (!fifo_full || pop_ok);
    // Head entry is shown directly from storage; forced to 0 so stale data never leaks.
    assign evt_ts    = fifo_empty ? '0 : fifo_dout;

    recog_evt_fifo #(
        .DW    (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (recognized),
        .pop   (evt_ready),
        .din   (ts_cnt),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt    <= '0;
            evt_count <= '0;
            dropped   <= 1'b0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            // Every pulse counts, accepted or not, until the counter tops out.
            if (recognized && (evt_count != {CNT_W{1'b1}})) begin
                evt_count <= evt_count + CNT_W'(1);
            end
            if (recognized && !push_ok) begin
                dropped <= 1'b1;
            end
        end
    end

    // Occupancy FSM tracking the level the FIFO will hold after this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (push_ok) begin
                        state <= ST_PARTIAL;
                    end
                end
                ST_PARTIAL: begin
                    if (push_ok && !pop_ok && (fifo_level == LVL_ALMOST)) begin
                        state <= ST_FULL;
                    end else if (pop_ok && !push_ok && (fifo_level == LVL_ONE)) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop_ok && !push_ok) begin
                        state <= ST_PARTIAL;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_recog_event_logger.sv
// Scoreboard bench for recog_event_logger with default parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_recog_event_logger;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       recognized = 1'b0;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [7:0] evt_ts;
    logic [7:0] evt_count;
    logic       dropped;
    logic [2:0] fifo_level;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q [$];
    logic [7:0] tb_ts;

    recog_event_logger dut (
        .clk        (clk),
        .reset      (reset),
        .recognized (recognized),
        .evt_ready  (evt_ready),
        .evt_valid  (evt_valid),
        .evt_ts     (evt_ts),
        .evt_count  (evt_count),
        .dropped    (dropped),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    // Bench copy of the free-running timestamp: value the next edge samples.
    always @(posedge clk or posedge reset) begin
        if (reset) tb_ts <= 8'd0;
        else       tb_ts <= tb_ts + 8'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every handshake that will complete on the next edge is checked.
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected: got ts %0d expected no entry", evt_ts);
            end else begin
                check("pop_ts", {24'd0, evt_ts}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ts(input logic [7:0] v);
        while (tb_ts != v) step();
    endtask

    task automatic do_reset();
        recognized = 1'b0;
        evt_ready  = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        #5 reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

    initial begin
        // Reset values
        do_reset();
        check("rst_valid", evt_valid, 0);
        check("rst_ts", evt_ts, 0);
        check("rst_count", evt_count, 0);
        check("rst_dropped", dropped, 0);
        check("rst_level", fifo_level, 0);

        // Single pulse at ts 5, consumer stalled
        wait_ts(8'd5);
        exp_q.push_back(8'd5);
        recognized = 1'b1;
        step();
        recognized = 1'b0;
        @(negedge clk);
        check("t1_valid", evt_valid, 1);
        check("t1_ts", evt_ts, 5);
        check("t1_level", fifo_level, 1);
        check("t1_count", evt_count, 1);
        step();
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        @(negedge clk);
        check("t1_empty_after_pop", evt_valid, 0);
        check("t1_q_drained", exp_q.size(), 0);

        // Overflow: 3,4,5,6 accepted, 10 dropped
        do_reset();
        exp_q.push_back(8'd3);
        exp_q.push_back(8'd4);
        exp_q.push_back(8'd5);
        exp_q.push_back(8'd6);
        wait_ts(8'd3);
        recognized = 1'b1;
        repeat (4) step();
        recognized = 1'b0;
        wait_ts(8'd10);
        recognized = 1'b1;
        step();
        recognized = 1'b0;
        @(negedge clk);
        check("t2_level", fifo_level, 4);
        check("t2_dropped", dropped, 1);
        check("t2_count", evt_count, 5);
        check("t2_head", evt_ts, 3);
        step();
        evt_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        check("t2_drained_valid", evt_valid, 0);
        check("t2_drained_level", fifo_level, 0);
        check("t2_q_drained", exp_q.size(), 0);

        // Pop while empty is ignored
        repeat (3) step();
        @(negedge clk);
        check("t6_level", fifo_level, 0);
        check("t6_valid", evt_valid, 0);
        check("t6_ts", evt_ts, 0);
        step();
        evt_ready = 1'b0;

        // Full queue, push and pop on the same edge
        do_reset();
        exp_q.push_back(8'd12);
        exp_q.push_back(8'd13);
        exp_q.push_back(8'd14);
        exp_q.push_back(8'd15);
        wait_ts(8'd12);
        recognized = 1'b1;
        repeat (4) step();
        recognized = 1'b0;
        @(negedge clk);
        check("t3_full_level", fifo_level, 4);
        step();
        exp_q.push_back(8'd20);
        wait_ts(8'd20);
        recognized = 1'b1;
        evt_ready  = 1'b1;
        step();
        recognized = 1'b0;
        evt_ready  = 1'b0;
        @(negedge clk);
        check("t3_level", fifo_level, 4);
        check("t3_dropped", dropped, 0);
        check("t3_count", evt_count, 5);
        check("t3_head", evt_ts, 13);
        step();
        evt_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        check("t3_drained_valid", evt_valid, 0);
        check("t3_q_drained", exp_q.size(), 0);
        step();
        evt_ready = 1'b0;

        // Timestamp wrap: run past 255 cycles, pulse at wrapped ts 2
        wait_ts(8'd2);
        exp_q.push_back(8'd2);
        recognized = 1'b1;
        step();
        recognized = 1'b0;
        @(negedge clk);
        check("t4_valid", evt_valid, 1);
        check("t4_ts", evt_ts, 2);
        check("t4_count", evt_count, 6);
        step();
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        @(negedge clk);
        check("t4_q_drained", exp_q.size(), 0);

        // Saturation: 300 back-to-back pulses with the consumer always ready
        step();
        recognized = 1'b1;
        evt_ready  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back(tb_ts);
            step();
        end
        recognized = 1'b0;
        step();
        @(negedge clk);
        check("t5_count_sat", evt_count, 255);
        check("t5_dropped", dropped, 0);
        check("t5_level", fifo_level, 0);
        check("t5_q_drained", exp_q.size(), 0);
        step();
        evt_ready = 1'b0;

        // Asynchronous reset with level 3 and dropped set
        do_reset();
        exp_q.push_back(8'd3);
        exp_q.push_back(8'd4);
        exp_q.push_back(8'd5);
        exp_q.push_back(8'd6);
        wait_ts(8'd3);
        recognized = 1'b1;
        repeat (5) step();
        recognized = 1'b0;
        evt_ready  = 1'b1;
        step();
        evt_ready  = 1'b0;
        @(negedge clk);
        check("t7_pre_level", fifo_level, 3);
        check("t7_pre_dropped", dropped, 1);
        check("t7_pre_head", evt_ts, 4);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("t7_async_valid", evt_valid, 0);
        check("t7_async_ts", evt_ts, 0);
        check("t7_async_count", evt_count, 0);
        check("t7_async_dropped", dropped, 0);
        check("t7_async_level", fifo_level, 0);
        #4 reset = 1'b0;
        exp_q.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/recog_event_logger.md
# recog_event_logger

Downstream stage of the 3-bit sequence recognizer. The recognizer raises a one-cycle `recognized` pulse for each detected pattern. This block stamps each pulse with a free-running cycle timestamp and queues the stamps in a small FIFO. Queued entries are presented to a consumer over a valid/ready handshake, together with a saturating event total and a sticky overflow flag.

## Interface
- `TS_W`, default 8: timestamp counter width.
- `DEPTH`, default 4: FIFO entries; must be a power of 2 and at least 2.
- `CNT_W`, default 8: width of the event total.

Ports:
- `clk`  in  1  single clock; all flops on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `recognized`  in  1  event pulse from the recognizer, sampled each rising edge.
- `evt_ready`  in  1  consumer accepts the head entry.
- `evt_valid`  out  1  FIFO non-empty; head entry on `evt_ts`.
- `evt_ts`  out  TS_W  timestamp of the head entry; 0 when empty.
- `evt_count`  out  CNT_W  total accepted-or-dropped events, saturating.
- `dropped`  out  1  sticky; set when an event is lost because the FIFO is full.
- `fifo_level`  out  log2(DEPTH)+1  current occupancy.

## Operation
- `ts_cnt` (TS_W bits) increments every cycle and wraps from 2^TS_W−1 to 0.
- Push: `recognized`=1 at an edge writes the pre-increment `ts_cnt` at the write pointer.
  - Accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the event is discarded and `dropped` is set to 1.
- Pop: `evt_valid` && `evt_ready` at an edge advances the read pointer. `evt_ready` while empty is ignored.
- Simultaneous push and pop: level is unchanged, and both pointers advance.
- `evt_count` adds 1 on every `recognized` pulse, including dropped ones, and holds at 2^CNT_W−1.
- Pointers are log2(DEPTH) bits and wrap naturally. Full and empty are derived from the `fifo_level` register, not from pointer equality.
- Reset clears `ts_cnt`, both pointers, `fifo_level`, `evt_count` and `dropped`. Storage contents are don't-care.
- Reset values of the outputs: `evt_valid`=0, `evt_ts`=0, `evt_count`=0, `dropped`=0, `fifo_level`=0.
- Reset mid-operation: all queued entries are discarded, and `dropped` clears.
- Control FSM, three states derived from `fifo_level`:
  - EMPTY: level 0.
  - PARTIAL: 0 < level < DEPTH.
  - FULL: level = DEPTH.
  - Transitions by push only, pop only, both, or neither, as defined above.

## Timing
- Push-to-visible latency is 1 cycle. There is no empty bypass: a pulse at edge N gives `evt_valid`=1 after edge N.
- `evt_valid`, `evt_ts` and `fifo_level` are registered-state outputs. `evt_ts` is the storage read at the read pointer, gated to 0 when empty, with no extra register.
- After a pop at edge N, the next entry (or `evt_valid`=0) appears after edge N.
- `dropped` and `evt_count` update after the edge that sampled the pulse.
- Back-to-back `recognized` pulses on consecutive cycles are each logged. The recognizer cannot currently produce them, but the block must support them.

## Structure
- Shared package `recog_pkg` holds:
  - default `TS_W`/`DEPTH`/`CNT_W` constants;
  - the FSM state enum (EMPTY, PARTIAL, FULL);
  - the `clog2`-style width helper for pointers and level.
- One sub-module: `recog_evt_fifo`, a synchronous FIFO with push/pop/full/empty/level and an asynchronous active-high reset.
- The top level holds the timestamp counter, event counter, drop flag and FSM.

## Test plan
- Reset, then a pulse when `ts_cnt`=5 with `evt_ready`=0 → after that edge: `evt_valid`=1, `evt_ts`=5, `fifo_level`=1, `evt_count`=1.
- Pulses at `ts_cnt`=3,4,5,6 (consecutive), then one at 10, with `evt_ready`=0 → level 4, `dropped`=1, `evt_count`=5. Drain with `evt_ready`=1 → `evt_ts` 3,4,5,6, then `evt_valid`=0.
- FIFO full and `evt_ready`=1 with a pulse at `ts_cnt`=20 on the same edge → level stays 4, `dropped` stays 0, and 20 is the last entry.
- Run past 255 cycles, pulse at wrapped `ts_cnt`=2 → `evt_ts`=2. Then 300 pulses with `evt_ready`=1 → `evt_count`=255, saturated.
- Assert `reset` asynchronously mid-cycle with level 3 and `dropped`=1 → outputs go to 0 immediately, before the next edge.
- Pop with `evt_ready`=1 while empty, no pulse → `fifo_level` stays 0 and `evt_valid` stays 0.
